// File: rtl/path_gen_pkg.sv
// Shared widths, FSM states, FIFO entry layout and the fixed-point step
// function used by the path generator and by its reference model.
package path_gen_pkg;

  localparam int unsigned DATA_W_DEF    = 12;
  localparam int unsigned FRAC_W_DEF    = 6;
  localparam int unsigned EPS_W_DEF     = 13;
  localparam int unsigned EPS_FRAC_DEF  = 10;
  localparam int unsigned STEPS_DEF     = 8;
  localparam int unsigned OUT_DEPTH_DEF = 2;
  localparam int unsigned STEP_W_DEF    = $clog2(STEPS_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] path;
    logic [STEP_W_DEF-1:0] step;
    logic                  last;
  } fifo_entry_t;

  typedef struct packed {
    logic [63:0] val;
    logic        sat;
  } step_res_t;

  // S*(w + q*eps) at full precision, floor-shifted back to the S format, then clamped.
  function automatic step_res_t step_fn(input longint s, input longint w,
                                        input longint q, input longint eps,
                                        input int unsigned data_w,
                                        input int unsigned frac_w,
                                        input int unsigned eps_frac);
    longint    f;
    longint    prod;
    longint    raw;
    longint    max_v;
    step_res_t r;
    f     = (w <<< eps_frac) + q * eps;
    prod  = s * f;
    raw   = prod >>> (frac_w + eps_frac);
    max_v = (64'sd1 <<< data_w) - 64'sd1;
    r.val = 64'(raw);
    r.sat = 1'b0;
    if (raw < 64'sd0) begin
      r.val = '0;
      r.sat = 1'b1;
    end else if (raw > max_v) begin
      r.val = 64'(max_v);
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/path_out_fifo.sv
// Circular-buffer output FIFO with a registered occupancy count.
module path_out_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && (cnt != FULL_CNT);
  assign do_pop  = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/path_gen_param.sv
// Monte-Carlo price-path generator: one multiplicative fixed-point step per
// accepted eps beat, results streamed through a small output FIFO.
module path_gen_param
  import path_gen_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned FRAC_W    = FRAC_W_DEF,
  parameter int unsigned EPS_W     = EPS_W_DEF,
  parameter int unsigned EPS_FRAC  = EPS_FRAC_DEF,
  parameter int unsigned STEPS     = STEPS_DEF,
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DATA_W-1:0]          w,
  input  logic [DATA_W-1:0]          q,
  input  logic [DATA_W-1:0]          S0,
  input  logic                       eps_valid,
  input  logic signed [EPS_W-1:0]    eps,
  output logic                       eps_ready,
  output logic                       path_valid,
  output logic [DATA_W-1:0]          path,
  output logic [$clog2(STEPS)-1:0]   path_step,
  output logic                       path_last,
  input  logic                       path_ready,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int unsigned STEP_W  = $clog2(STEPS);
  localparam int unsigned ENTRY_W = DATA_W + STEP_W + 1;
  localparam int unsigned CNT_W   = $clog2(OUT_DEPTH + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(OUT_DEPTH);

  state_t              state_q, state_n;
  logic [DATA_W-1:0]   s_q, s_n;
  logic [DATA_W-1:0]   w_q, w_n;
  logic [DATA_W-1:0]   q_q, q_n;
  logic [STEP_W-1:0]   step_q, step_n;
  logic                sat_q, sat_n;
  logic                busy_q;

  logic [DATA_W-1:0]   src_s, src_w, src_q;
  logic [STEP_W-1:0]   src_step;
  logic                room;
  logic                accept;
  logic                pop;
  logic                src_last;
  step_res_t           res;
  logic [DATA_W-1:0]   s_next;
  logic [ENTRY_W-1:0]  entry;
  logic [ENTRY_W-1:0]  fifo_dout;
  logic                fifo_valid;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    cnt_n;
  logic                unused_hi;

  // Next state and step datapath; a start in IDLE feeds S0/w/q straight to the step.
  always_comb begin
    state_n   = state_q;
    s_n       = s_q;
    w_n       = w_q;
    q_n       = q_q;
    step_n    = step_q;
    sat_n     = sat_q;
    src_s     = s_q;
    src_w     = w_q;
    src_q     = q_q;
    src_step  = step_q;
    eps_ready = 1'b0;
    room      = (fifo_count < DEPTH_C);

    case (state_q)
      IDLE: begin
        eps_ready = start && room;
        if (start) begin
          src_s    = S0;
          src_w    = w;
          src_q    = q;
          src_step = '0;
          s_n      = S0;
          w_n      = w;
          q_n      = q;
          step_n   = '0;
          sat_n    = 1'b0;
          state_n  = RUN;
        end
      end
      RUN:     eps_ready = room;
      default: state_n = IDLE;
    endcase

    accept   = eps_valid && eps_ready;
    res      = step_fn(64'(src_s), 64'(src_w), 64'(src_q), 64'(eps),
                       DATA_W, FRAC_W, EPS_FRAC);
    s_next   = DATA_W'(res.val);
    src_last = (src_step == LAST_STEP);
    entry    = {s_next, src_step, src_last};

    if (accept) begin
      s_n   = s_next;
      sat_n = sat_n | res.sat;
      if (src_last) begin
        step_n  = '0;
        state_n = IDLE;
      end else begin
        step_n = src_step + STEP_W'(1);
      end
    end

    pop   = fifo_valid && path_ready;
    cnt_n = fifo_count + CNT_W'(accept) - CNT_W'(pop);
  end

  // Clamp guarantees the upper bits of the step result are zero.
  assign unused_hi = ^res.val[63:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      w_q     <= '0;
      q_q     <= '0;
      step_q  <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      w_q     <= w_n;
      q_q     <= q_n;
      step_q  <= step_n;
      sat_q   <= sat_n;
      busy_q  <= (state_n == RUN) || (cnt_n != '0);
    end
  end

  path_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (entry),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign path_valid                   = fifo_valid;
  assign {path, path_step, path_last} = fifo_dout;
  assign busy                         = busy_q;
  assign sat_flag                     = sat_q;

endmodule

// File: tb/tb_path_gen_param.sv
// Directed bench for path_gen_param with a scoreboard of expected FIFO beats.
module tb_path_gen_param;
  import path_gen_pkg::*;

  localparam int unsigned DW    = 12;
  localparam int unsigned SW    = 3;
  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DW-1:0]     w, q, s0;
  logic              eps_valid;
  logic signed [12:0] eps;
  logic              eps_ready;
  logic              path_valid;
  logic [DW-1:0]     path;
  logic [SW-1:0]     path_step;
  logic              path_last;
  logic              path_ready;
  logic              busy;
  logic              sat_flag;

  always #5 clk = ~clk;

  path_gen_param dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .w          (w),
    .q          (q),
    .S0         (s0),
    .eps_valid  (eps_valid),
    .eps        (eps),
    .eps_ready  (eps_ready),
    .path_valid (path_valid),
    .path       (path),
    .path_step  (path_step),
    .path_last  (path_last),
    .path_ready (path_ready),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  int            total = 0;
  int            bad   = 0;
  fifo_entry_t   sb[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_v [8];
  bit            m_run = 1'b0;
  logic [DW-1:0] m_s = '0, m_w = '0, m_q = '0;
  logic [SW-1:0] m_step = '0;
  logic          m_sat = 1'b0;
  int            acc_cnt = 0;
  int            acc0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model at negedge, advance model, step past posedge.
  task automatic cyc();
    logic        exp_ready;
    step_res_t   r;
    fifo_entry_t e;
    @(negedge clk);
    exp_ready = (sb.size() < int'(DEPTH)) && (m_run || start);
    chk("eps_ready", 32'(eps_ready), 32'(exp_ready));
    chk("path_valid", 32'(path_valid), 32'(sb.size() != 0));
    chk("busy", 32'(busy), 32'(m_run || (sb.size() != 0)));
    chk("sat_flag", 32'(sat_flag), 32'(m_sat));
    if (sb.size() != 0) begin
      chk("path", 32'(path), 32'(sb[0].path));
      chk("path_step", 32'(path_step), 32'(sb[0].step));
      chk("path_last", 32'(path_last), 32'(sb[0].last));
      if (path_ready) begin
        got.push_back(path);
        void'(sb.pop_front());
      end
    end
    if (!m_run && start) begin
      m_s = s0; m_w = w; m_q = q; m_step = '0; m_sat = 1'b0; m_run = 1'b1;
    end
    if (eps_valid && exp_ready) begin
      r = step_fn(64'(m_s), 64'(m_w), 64'(m_q), 64'(eps), DW, 6, 10);
      e.path = DW'(r.val);
      e.step = m_step;
      e.last = (m_step == SW'(7));
      sb.push_back(e);
      m_s   = e.path;
      m_sat = m_sat | r.sat;
      acc_cnt++;
      if (e.last) begin
        m_run  = 1'b0;
        m_step = '0;
      end else begin
        m_step = m_step + SW'(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    eps_valid = 1'b0;
    start     = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) cyc();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_path(input logic [DW-1:0] sv, input logic [DW-1:0] wv,
                          input logic [DW-1:0] qv, input logic signed [12:0] ev,
                          input bit rnd);
    start = 1'b1; s0 = sv; w = wv; q = qv;
    eps_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      eps = rnd ? 13'($urandom_range(0, 8191)) : ev;
      cyc();
      start = 1'b0;
    end
    drain();
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("%s_v%0d", tag, i), 32'(got[i]), 32'(exp_v[i]));
    got.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(path_valid), 32'd0);
    chk({tag, "_path"}, 32'(path), 32'd0);
    chk({tag, "_step"}, 32'(path_step), 32'd0);
    chk({tag, "_last"}, 32'(path_last), 32'd0);
    chk({tag, "_eps_ready"}, 32'(eps_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sat"}, 32'(sat_flag), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; w = '0; q = '0; s0 = '0;
    eps_valid = 1'b0; eps = '0; path_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // identity
    run_path(12'h400, 12'd64, 12'd0, 13'sd0, 1'b0);
    exp_v = '{12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400};
    check_got("identity");
    chk("identity_sat", 32'(sat_flag), 32'd0);

    // growth into upper saturation
    run_path(12'h400, 12'd64, 12'd64, 13'sd512, 1'b0);
    exp_v = '{12'h600, 12'h900, 12'hD80, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    check_got("growth");
    chk("growth_sat", 32'(sat_flag), 32'd1);

    // negative factor clamps to zero
    run_path(12'h400, 12'd64, 12'd64, -13'sd2048, 1'b0);
    exp_v = '{default: 12'h000};
    check_got("negA");
    chk("negA_sat", 32'(sat_flag), 32'd1);

    // floor truncation, sat cleared by the new start
    run_path(12'd3, 12'd64, 12'd32, -13'sd512, 1'b0);
    exp_v = '{12'd2, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    check_got("negB");
    chk("negB_sat", 32'(sat_flag), 32'd0);

    // backpressure: only DEPTH beats accepted while the sink stalls
    path_ready = 1'b0;
    start = 1'b1; s0 = 12'h100; w = 12'd70; q = 12'd20; eps_valid = 1'b1;
    acc0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      eps = 13'($urandom_range(0, 8191));
      cyc();
      start = 1'b0;
      chk("bp_busy", 32'(busy), 32'd1);
    end
    chk("bp_accepts", 32'(acc_cnt - acc0), 32'd2);
    chk("bp_full_ready", 32'(eps_ready), 32'd0);
    path_ready = 1'b1;
    for (int i = 0; i < 40 && m_run; i++) begin
      eps = 13'($urandom_range(0, 8191));
      cyc();
    end
    drain();
    chk("bp_total_accepts", 32'(acc_cnt - acc0), 32'd8);
    chk("bp_len", 32'(got.size()), 32'd8);
    got.delete();

    // back-to-back paths with ignored starts during RUN
    start = 1'b1; s0 = 12'h200; w = 12'd64; q = 12'd16; eps_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      eps = 13'($urandom_range(0, 8191));
      if (i == 3 || i == 5) begin
        start = 1'b1; s0 = 12'hFFF; w = 12'hFFF; q = 12'hFFF;
      end else if (i > 0) begin
        start = 1'b0;
      end
      cyc();
    end
    start = 1'b1; s0 = 12'h080; w = 12'd80; q = 12'd8; eps = 13'sd0;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      eps = 13'($urandom_range(0, 8191));
      cyc();
    end
    drain();
    chk("b2b_len", 32'(got.size()), 32'd16);
    if (got.size() > 8) chk("b2b_p2_step0", 32'(got[8]), 32'h0A0);
    got.delete();

    // async reset in the middle of a path
    start = 1'b1; s0 = 12'h300; w = 12'd66; q = 12'd40; eps_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eps = 13'($urandom_range(0, 8191));
      cyc();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #2 check_reset_outputs("midreset");
    sb.delete(); got.delete();
    m_run = 1'b0; m_sat = 1'b0; m_step = '0; m_s = '0;
    eps_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_path(12'h180, 12'd60, 12'd50, 13'sd0, 1'b1);
    chk("post_reset_len", 32'(got.size()), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/path_gen_param.md
Name: path_gen_param

Overview:
Parametrised next-generation Monte-Carlo price-path generator for the option-pricing datapath. Per path it latches w, q and S0, then consumes one epsilon per accepted beat. It applies the multiplicative step S(k+1) = S(k) * (w + q*eps(k)) in fixed point, with saturation. Results go through an output FIFO with valid/ready backpressure, so back-to-back paths stream without gaps and can feed the payoff/accumulator stage.

Parameters:
DATA_W, 12, width of S0, w, q and path (unsigned)
FRAC_W, 6, fraction bits of S0, w, q and path
EPS_W, 13, width of eps (signed two's complement)
EPS_FRAC, 10, fraction bits of eps
STEPS, 8, steps per path (>=2)
OUT_DEPTH, 2, output FIFO entries (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse: latch w/q/S0 and begin a path; honoured only in IDLE
w  in  DATA_W  drift factor, unsigned
q  in  DATA_W  volatility factor, unsigned
S0  in  DATA_W  initial price, unsigned
eps_valid  in  1  eps beat valid
eps  in  EPS_W  normal sample, signed
eps_ready  out  1  eps beat accepted when eps_valid && eps_ready
path_valid  out  1  FIFO head valid
path  out  DATA_W  price at step path_step+1
path_step  out  $clog2(STEPS)  step index 0..STEPS-1
path_last  out  1  head is final step of its path
path_ready  in  1  downstream pop
busy  out  1  RUN state or FIFO non-empty
sat_flag  out  1  sticky: any step of current path saturated

Behaviour:
- Reset (async assert, sync release): state=IDLE, S=0, step=0, FIFO empty, path_valid=0, path/path_step/path_last=0, eps_ready=0, busy=0, sat_flag=0.
- FSM IDLE/RUN. room = (fifo_count < OUT_DEPTH), using the registered count; no pop-through.
- IDLE: eps_ready = start && room. On start: latch w, q, S0; clear sat_flag; go to RUN with step=0. If eps is accepted in the same cycle, it is step 0 and uses S0 directly (start coincident with first eps is the normal case). start while RUN is ignored.
- RUN: eps_ready = room. Each accept pushes {S_next, step, step==STEPS-1}, sets S <= S_next and step++. The accept with step==STEPS-1 returns the FSM to IDLE. A new start may then arrive on the very next cycle while the FIFO still drains.
- Arithmetic, full precision with no intermediate truncation:
  - f = (w << EPS_FRAC) + q*eps, signed, width DATA_W+EPS_W+2.
  - prod = S*f, signed.
  - S_next_raw = prod >>> (FRAC_W+EPS_FRAC), arithmetic shift, i.e. truncation toward -inf.
  - Clamp: raw < 0 gives 0; raw > 2^DATA_W-1 gives 2^DATA_W-1; either case sets sat_flag.
  - The saturated value is the value carried to the next step.
- Latency: eps accepted at edge N gives path_valid high after edge N when the FIFO was empty. Sustained throughput is 1 step/cycle when path_ready=1 and OUT_DEPTH>=2. With OUT_DEPTH=1 throughput is 1 step per 2 cycles.
- FIFO: pop on path_valid && path_ready. Push and pop in the same cycle is legal when not full. When full, eps_ready=0 and S/step hold.
- eps_valid=0 in RUN: state holds indefinitely with no timeout.
- Reset mid-path: all state is discarded, including FIFO contents.
- sat_flag stays set until the next accepted start.

Decomposition:
- Package path_gen_pkg holds:
  - default widths/fractions
  - state enum {IDLE, RUN}
  - FIFO entry struct {path, step, last}
  - a step function implementing f/prod/shift/clamp, shared with the bench reference model
- Sub-module path_out_fifo: parametrised by entry width and OUT_DEPTH; circular buffer with registered count.

Test Plan:
Defaults throughout: FRAC_W=6, EPS_FRAC=10, so w=64 is 1.0 and eps=512 is 0.5.
- Identity path: S0=0x400, w=64, q=0, start and 8 eps beats back-to-back, path_ready=1 -> paths 0x400 x8, path_step 0..7, path_last only on step 7, sat_flag=0, eps_ready never drops.
- Growth with upper saturation: S0=0x400, w=64, q=64, eps=512 x8 -> 0x600, 0x900, 0xD80, 0xFFF, 0xFFF, 0xFFF, 0xFFF, 0xFFF; sat_flag rises with step 3 and stays set.
- Negative factor and truncation, two separate paths:
  - Path A: S0=0x400, w=64, q=64, eps=-2048 -> f=-1.0, all outputs 0, sat_flag=1.
  - Path B (after a new start): S0=3, w=64, q=32, eps=-512 -> 2, 1, 0, 0, ...; sat_flag cleared at that start.
- Backpressure: path_ready=0 for 10 cycles mid-path -> exactly OUT_DEPTH(=2) beats accepted then eps_ready=0. On release, values and order are unchanged with no duplicates or drops. busy=1 throughout.
- Back-to-back paths: start on the cycle after path 1's last accept, with different w/q/S0 -> path 2 step 0 uses the new S0. No interleaving in the FIFO. start pulses issued during RUN are ignored.
- Async reset mid-path: rst_n low for half a cycle at step 4 -> all outputs 0 immediately. After release a fresh path matches the reference model from step 0.
